// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI4 constants and LSU bus-master FSM encoding.
//   BURST_*  : AXBURST encodings
//   RESP_*   : RRESP/BRESP encodings
//   SIZE_*   : core request sizes (byte/half/word)
//   state_e  : bus-master FSM states
//   req_misaligned() : flags illegal size or an address not aligned to size
package ysyx_24110006_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_24110006_lane_align.sv
// Combinational byte-lane alignment between an LSB-aligned core view and
// the 32-bit AXI data bus.
//   addr_lo_i : byte offset within the word
//   size_i    : 0=byte 1=half 2=word
//   wdata_i   : store data, LSB-aligned      -> wdata_o : shifted onto its lanes
//                                            -> wstrb_o : byte enables for the access
//   rdata_i   : raw bus read word            -> rdata_o : right-aligned, zero-extended
module ysyx_24110006_lane_align
  import ysyx_24110006_axi_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [3:0]  strb_base;
  logic [31:0] rd_shift;

  assign sh       = {addr_lo_i, 3'b000};
  assign wdata_o  = wdata_i << sh;
  assign rd_shift = rdata_i >> sh;
  assign wstrb_o  = strb_base << addr_lo_i;

  always_comb begin
    strb_base = 4'b0000;
    rdata_o   = rd_shift;
    case (size_i)
      SIZE_B: begin
        strb_base = 4'b0001;
        rdata_o   = {24'b0, rd_shift[7:0]};
      end
      SIZE_H: begin
        strb_base = 4'b0011;
        rdata_o   = {16'b0, rd_shift[15:0]};
      end
      SIZE_W: begin
        strb_base = 4'b1111;
        rdata_o   = rd_shift;
      end
      default: begin
        strb_base = 4'b0000;
        rdata_o   = rd_shift;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_lsu_axi_master.sv
// AXI4 initiator for the core's load/store port. One single-beat (LEN=0,
// INCR) transaction at a time; misaligned or illegal-size requests are
// answered with an error and never reach the bus.
//   i_clock/i_reset : clock, synchronous active-high reset
//   i_req_* / o_req_ready : request port (accepted only in IDLE)
//   o_rsp_* / i_rsp_ready : response port (held until accepted)
//   o_axi_aw*/w*/b*/ar*/r*, i_axi_* : AXI4 master interface
module ysyx_24110006_lsu_axi_master
  import ysyx_24110006_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  // core request / response
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  // AW
  output logic [3:0]  o_axi_awid,
  output logic [31:0] o_axi_awaddr,
  output logic [7:0]  o_axi_awlen,
  output logic [2:0]  o_axi_awsize,
  output logic [1:0]  o_axi_awburst,
  output logic        o_axi_awvalid,
  input  logic        i_axi_awready,
  // W
  output logic [31:0] o_axi_wdata,
  output logic [3:0]  o_axi_wstrb,
  output logic        o_axi_wlast,
  output logic        o_axi_wvalid,
  input  logic        i_axi_wready,
  // B
  input  logic [3:0]  i_axi_bid,
  input  logic [1:0]  i_axi_bresp,
  input  logic        i_axi_bvalid,
  output logic        o_axi_bready,
  // AR
  output logic [3:0]  o_axi_arid,
  output logic [31:0] o_axi_araddr,
  output logic [7:0]  o_axi_arlen,
  output logic [2:0]  o_axi_arsize,
  output logic [1:0]  o_axi_arburst,
  output logic        o_axi_arvalid,
  input  logic        i_axi_arready,
  // R
  input  logic [3:0]  i_axi_rid,
  input  logic [31:0] i_axi_rdata,
  input  logic [1:0]  i_axi_rresp,
  input  logic        i_axi_rlast,
  input  logic        i_axi_rvalid,
  output logic        o_axi_rready
);

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rsp_rdata_q;
  logic [1:0]  size_q;
  logic        arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
  logic        aw_done_q, w_done_q;
  logic        rsp_valid_q, rsp_err_q;

  logic        aw_hs, w_hs, aw_done_d, w_done_d;
  logic [31:0] wdata_al, rdata_al;
  logic [3:0]  wstrb_al;

  // Single-beat transactions: ID/RLAST carry no information here.
  logic unused_ok;
  assign unused_ok = ^{i_axi_bid, i_axi_rid, i_axi_rlast};

  ysyx_24110006_lane_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .wdata_i   (wdata_q),
    .rdata_i   (i_axi_rdata),
    .wdata_o   (wdata_al),
    .wstrb_o   (wstrb_al),
    .rdata_o   (rdata_al)
  );

  // AW and W complete independently; B is entered once both have landed,
  // including when both handshake in the same cycle.
  assign aw_hs     = awvalid_q & i_axi_awready;
  assign w_hs      = wvalid_q & i_axi_wready;
  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q | w_hs;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_req_valid) begin
          addr_q    <= i_req_addr;
          size_q    <= i_req_size;
          wdata_q   <= i_req_wdata;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (req_misaligned(i_req_size, i_req_addr[1:0])) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end else if (i_req_wen) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_AW_W;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: if (i_axi_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_R;
        end
        S_R: if (i_axi_rvalid) begin
          rready_q    <= 1'b0;
          rsp_rdata_q <= rdata_al;
          rsp_err_q   <= (i_axi_rresp != RESP_OKAY);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_AW_W: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: if (i_axi_bvalid) begin
          bready_q    <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= (i_axi_bresp != RESP_OKAY);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RSP: if (i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready   = (state_q == S_IDLE);
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_err     = rsp_err_q;

  assign o_axi_awid    = AXI_ID;
  assign o_axi_awaddr  = addr_q;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = {1'b0, size_q};
  assign o_axi_awburst = BURST_INCR;
  assign o_axi_awvalid = awvalid_q;

  assign o_axi_wdata   = wdata_al;
  assign o_axi_wstrb   = wstrb_al;
  assign o_axi_wlast   = 1'b1;
  assign o_axi_wvalid  = wvalid_q;

  assign o_axi_bready  = bready_q;

  assign o_axi_arid    = AXI_ID;
  assign o_axi_araddr  = addr_q;
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = {1'b0, size_q};
  assign o_axi_arburst = BURST_INCR;
  assign o_axi_arvalid = arvalid_q;

  assign o_axi_rready  = rready_q;

endmodule
